// File: rtl/val2_shift_sequencer_pkg.sv
// Shared encodings and default widths for the sequential Val2 shifter.
package val2_shift_sequencer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 5;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/val2_shift_step.sv
// One-bit shift/rotate step: returns d moved by a single position for the given op.
module val2_shift_step
    import val2_shift_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            SH_LSL:  q = {d[DATA_W-2:0], 1'b0};
            SH_LSR:  q = {1'b0, d[DATA_W-1:1]};
            SH_ASR:  q = {d[DATA_W-1], d[DATA_W-1:1]};
            SH_ROR:  q = {d[0], d[DATA_W-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle Val2 generator: decodes the shifter operand, then shifts one bit per
// cycle while stalling the pipeline; the result is presented for one DONE cycle.
module val2_shift_sequencer
    import val2_shift_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [11:0]       shifter_operand,
    input  logic              imm,
    input  logic              is_for_memory,
    input  logic [DATA_W-1:0] val_Rm,
    output logic [DATA_W-1:0] val2_out,
    output logic              done,
    output logic              busy,
    output logic              stall
);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] step_q;

    logic [1:0]        dec_op;
    logic [CNT_W-1:0]  dec_n;
    logic [DATA_W-1:0] dec_data;
    logic              accept;

    // Memory-offset form wins over immediate form, which wins over register form.
    always_comb begin
        dec_op   = SH_LSL;
        dec_n    = '0;
        dec_data = DATA_W'(shifter_operand);
        if (is_for_memory) begin
            dec_op   = SH_LSL;
            dec_n    = '0;
            dec_data = DATA_W'(shifter_operand);
        end else if (imm) begin
            dec_op   = SH_ROR;
            dec_n    = CNT_W'({shifter_operand[11:8], 1'b0});
            dec_data = DATA_W'(shifter_operand[7:0]);
        end else begin
            dec_op   = shifter_operand[6:5];
            dec_n    = CNT_W'(shifter_operand[11:7]);
            dec_data = val_Rm;
        end
    end

    assign accept = (state == ST_IDLE) && start && !flush;

    val2_shift_step #(.DATA_W(DATA_W)) u_step (
        .op (op_q),
        .d  (data_q),
        .q  (step_q)
    );

    // val2_out is loaded on the edge into DONE so it is valid during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= SH_LSL;
            data_q   <= '0;
            val2_out <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= dec_op;
                        data_q <= dec_data;
                        if (dec_n == '0) begin
                            state    <= ST_DONE;
                            cnt      <= '0;
                            val2_out <= dec_data;
                        end else begin
                            state <= ST_SHIFT;
                            cnt   <= dec_n;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_q;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= ST_DONE;
                        val2_out <= step_q;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign done  = (state == ST_DONE) && !flush;
    assign busy  = (state != ST_IDLE);
    assign stall = accept || (state == ST_SHIFT);

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Directed bench for val2_shift_sequencer with an expected-result scoreboard.
module tb_val2_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [11:0] shifter_operand;
    logic        imm;
    logic        is_for_memory;
    logic [31:0] val_Rm;
    logic [31:0] val2_out;
    logic        done;
    logic        busy;
    logic        stall;

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    val2_shift_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .flush           (flush),
        .shifter_operand (shifter_operand),
        .imm             (imm),
        .is_for_memory   (is_for_memory),
        .val_Rm          (val_Rm),
        .val2_out        (val2_out),
        .done            (done),
        .busy            (busy),
        .stall           (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request, pushes its expectation, then waits (bounded) for done.
    task automatic do_op(input string tag, input logic [11:0] opd, input logic im,
                         input logic mem, input logic [31:0] rm,
                         input logic [31:0] ev, input int el);
        int   cyc;
        int   stl;
        exp_t e;
        @(negedge clk);
        shifter_operand = opd; imm = im; is_for_memory = mem; val_Rm = rm; start = 1'b1;
        #1 chk({tag, ":stall_acc"}, 32'(stall), 32'd1);
        sb.push_back('{val: ev, lat: el});
        @(posedge clk);
        stl = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (!done) stl += int'(stall);
        end while (!done && cyc < 40);
        chk({tag, ":done"}, 32'(done), 32'd1);
        e = sb.pop_front();
        chk({tag, ":val"}, val2_out, e.val);
        chk({tag, ":lat"}, 32'(cyc), 32'(e.lat));
        chk({tag, ":stall_cycles"}, 32'(stl), 32'(e.lat));
        chk({tag, ":stall_done"}, 32'(stall), 32'd0);
        @(negedge clk);
        chk({tag, ":done_pulse"}, 32'(done), 32'd0);
        chk({tag, ":idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; shifter_operand = '0;
        imm = 1'b0; is_for_memory = 1'b0; val_Rm = '0;
        #12;
        chk("rst:val", val2_out, 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mem",     12'hABC, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0ABC, 1);
        do_op("imm_ror", 12'h2FF, 1'b1, 1'b0, 32'h0,         32'hF000_000F, 5);
        do_op("asr4",    12'h240, 1'b0, 1'b0, 32'h8000_0000, 32'hF800_0000, 5);
        do_op("lsr4",    12'h220, 1'b0, 1'b0, 32'h8000_0000, 32'h0800_0000, 5);
        do_op("lsl0",    12'h000, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1);
        do_op("ror31",   12'hFE0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32);
        do_op("lsl5",    12'h280, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_1FE0, 6);
        do_op("ror8",    12'h460, 1'b0, 1'b0, 32'h1234_5678, 32'h7812_3456, 9);

        // start together with flush in IDLE is not accepted
        @(negedge clk);
        shifter_operand = 12'h280; val_Rm = 32'h1; start = 1'b1; flush = 1'b1;
        #1 chk("sflush:stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("sflush:busy", 32'(busy), 32'd0);
        start = 1'b0; flush = 1'b0;

        // LSL #31, re-pulsed start ignored, flush on the 10th SHIFT cycle
        @(negedge clk);
        shifter_operand = 12'hF80; val_Rm = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("flush:busy_shift", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; shifter_operand = 12'h000;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        #1 chk("flush:done_low", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush:busy", 32'(busy), 32'd0);
        chk("flush:stall", 32'(stall), 32'd0);
        chk("flush:val_kept", val2_out, 32'h7812_3456);
        seen = 0;
        repeat (35) @(negedge clk) seen += int'(done);
        chk("flush:no_done", 32'(seen), 32'd0);

        // back-to-back: start held through DONE is taken only in the next IDLE cycle
        @(negedge clk);
        shifter_operand = 12'h000; val_Rm = 32'hCAFE_F00D; start = 1'b1;
        @(negedge clk);
        chk("b2b:done1", 32'(done), 32'd1);
        chk("b2b:stall_done", 32'(stall), 32'd0);
        chk("b2b:val1", val2_out, 32'hCAFE_F00D);
        val_Rm = 32'h0BAD_CAFE;
        @(negedge clk);
        chk("b2b:idle_acc_busy", 32'(busy), 32'd0);
        chk("b2b:idle_acc_stall", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b:done2", 32'(done), 32'd1);
        chk("b2b:val2", val2_out, 32'h0BAD_CAFE);
        @(negedge clk);

        // async reset mid-SHIFT
        @(negedge clk);
        shifter_operand = 12'hFE0; val_Rm = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst:val", val2_out, 32'd0);
        chk("arst:busy", 32'(busy), 32'd0);
        chk("arst:stall", 32'(stall), 32'd0);
        chk("arst:done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 12'h220, 1'b0, 1'b0, 32'h8000_0000, 32'h0800_0000, 5);

        chk("sb:empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
